// File: rtl/program_loader.sv
// Boot loader and memory-port arbiter for the single-cycle MIPS instruction memory.
// Receives a 16-bit word count and little-endian 32-bit words over a byte stream,
// writes them from word index 0 upward, and holds the CPU while loading. When idle
// or finished, the CPU fetch address passes straight through to the memory port.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [DATA_WIDTH-1:0] fetch_address,
    output logic [DATA_WIDTH-1:0] fetch_instruction,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StCheck,
        StRecv,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           word_count_q, word_count_d;
    // One extra bit so a full-depth load reaches MEMORY_DEPTH without wrapping
    logic [ADDR_WIDTH:0]   word_index_q, word_index_d;
    logic [1:0]            byte_index_q, byte_index_d;
    logic [DATA_WIDTH-1:0] shift_word_q, shift_word_d;
    logic                  byte_fire;

    // Only the word-index bits of the byte address select a memory word
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_address[DATA_WIDTH-1:ADDR_WIDTH+2], fetch_address[1:0]};

    assign byte_fire = byte_valid & byte_ready;

    // State and datapath registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            word_count_q <= '0;
            word_index_q <= '0;
            byte_index_q <= '0;
            shift_word_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_index_q <= word_index_d;
            byte_index_q <= byte_index_d;
            shift_word_q <= shift_word_d;
        end
    end

    // Next-state logic: length capture, bounds check, byte assembly and word writes
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        word_index_d = word_index_q;
        byte_index_d = byte_index_q;
        shift_word_d = shift_word_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    word_index_d = '0;
                    byte_index_d = '0;
                    state_d      = StLenLo;
                end
            end
            StLenLo: begin
                if (byte_fire) begin
                    word_count_d[7:0] = byte_data;
                    state_d           = StLenHi;
                end
            end
            StLenHi: begin
                if (byte_fire) begin
                    word_count_d[15:8] = byte_data;
                    state_d            = StCheck;
                end
            end
            StCheck: begin
                if (word_count_q == 16'd0) begin
                    state_d = StDone;
                end else if (word_count_q > 16'(MEMORY_DEPTH)) begin
                    state_d = StError;
                end else begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (byte_fire) begin
                    // First byte of a word lands in the least significant lane
                    shift_word_d[{byte_index_q, 3'b000} +: 8] = byte_data;
                    byte_index_d = byte_index_q + 2'd1;
                    if (byte_index_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_index_d = word_index_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                byte_index_d = '0;
                if (16'(word_index_q) + 16'd1 == word_count_q) begin
                    state_d = StDone;
                end else begin
                    state_d = StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake, status and memory-port mux; the CPU sees NOPs while held
    always_comb begin
        byte_ready       = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StRecv);
        cpu_hold         = !((state_q == StIdle) || (state_q == StDone));
        mem_write_enable = (state_q == StWrite);
        mem_write_data   = shift_word_q;
        done             = (state_q == StDone);
        error            = (state_q == StError);
        if (cpu_hold) begin
            mem_address       = word_index_q[ADDR_WIDTH-1:0];
            fetch_instruction = '0;
        end else begin
            mem_address       = fetch_address[ADDR_WIDTH+1:2];
            fetch_instruction = mem_read_data;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a behavioural program memory.
module tb_program_loader;

    localparam int unsigned MEMORY_DEPTH = 32;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH   = 5;

    logic                  clk        = 1'b0;
    logic                  reset      = 1'b0;
    logic                  start      = 1'b0;
    logic [7:0]            byte_data  = 8'h00;
    logic                  byte_valid = 1'b0;
    logic                  byte_ready;
    logic [DATA_WIDTH-1:0] fetch_address = '0;
    logic [DATA_WIDTH-1:0] fetch_instruction;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    int checks   = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
    logic                  mem_filled   = 1'b0;
    logic                  prev_we      = 1'b0;
    int                    double_we_cnt = 0;
    int                    ready_in_write_cnt = 0;
    logic [ADDR_WIDTH-1:0] wr_addr_log [$];
    logic [DATA_WIDTH-1:0] wr_data_log [$];

    always #5 clk = ~clk;

    program_loader #(
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .byte_data        (byte_data),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .fetch_address    (fetch_address),
        .fetch_instruction(fetch_instruction),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
        .cpu_hold         (cpu_hold),
        .done             (done),
        .error            (error)
    );

    assign mem_read_data = mem[mem_address];

    // Program memory and write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) mem[i] <= 32'hFFFF_0000 | 32'(i);
            mem_filled <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
            wr_addr_log.push_back(mem_address);
            wr_data_log.push_back(mem_write_data);
        end
        if (mem_write_enable && prev_we) double_we_cnt <= double_we_cnt + 1;
        if (mem_write_enable && byte_ready) ready_in_write_cnt <= ready_in_write_cnt + 1;
        prev_we <= mem_write_enable;
    end

    function automatic logic [31:0] full_word(input int i);
        return {8'(i), 8'(255 - i), 8'(i + 64), 8'hC3};
    endfunction

    // Present a byte from a negedge and return at the negedge after it transfers
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout got byte_ready=0 for 50 cycles, required 1 (byte %02h)", b);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_timeout got done=0, required 1", name);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        fetch_address = 32'h0000_0008;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_hold, byte_ready, mem_write_enable, done, error} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got hold/ready/we/done/err=%05b, required 00000",
                     {cpu_hold, byte_ready, mem_write_enable, done, error});
        end
        checks++;
        if (mem_address !== 5'd2) begin
            failures++;
            $display("FAIL reset_passthrough_addr got %0d, required 2", mem_address);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_recv;
        int n;
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        checks++;
        if (byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL recv_state got ready=%b hold=%b, required 1 1", byte_ready, cpu_hold);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, byte_ready, mem_write_enable, done, error} !== 5'b00000) begin
            failures++;
            $display("FAIL midreset_outputs got hold/ready/we/done/err=%05b, required 00000",
                     {cpu_hold, byte_ready, mem_write_enable, done, error});
        end
        @(negedge clk);
        reset = 1'b1;
        n = wr_addr_log.size();
        pulse_start;
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_check got hold=%b done=%b ready=%b, required 1 0 0",
                     cpu_hold, done, byte_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL len0_done got done=%b hold=%b, required 1 0", done, cpu_hold);
        end
        checks++;
        if (wr_addr_log.size() != n) begin
            failures++;
            $display("FAIL len0_no_write got %0d writes, required %0d", wr_addr_log.size(), n);
        end
    endtask

    task automatic test_two_words;
        logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                    8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int   lat;
        int   dbl;
        bit   seen;
        logic prev_hold;
        wr_addr_log.delete();
        wr_data_log.delete();
        dbl = double_we_cnt;
        fetch_address = 32'h0000_0004;
        lat = 0;
        seen = 1'b0;
        prev_hold = 1'b0;
        @(negedge clk);
        start = 1'b1;
        fork
            begin
                @(negedge clk);
                start = 1'b0;
                for (int i = 0; i < 10; i++) send_byte(stream[i]);
                byte_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    lat++;
                    if (lat == 5) begin
                        checks++;
                        if (fetch_instruction !== 32'h0000_0000) begin
                            failures++;
                            $display("FAIL load_fetch_nop got %08h, required 00000000",
                                     fetch_instruction);
                        end
                    end
                    if (done) begin
                        seen = 1'b1;
                        break;
                    end
                    prev_hold = cpu_hold;
                end
            end
        join
        checks++;
        if (!seen || lat != 14) begin
            failures++;
            $display("FAIL two_latency got %0d cycles (seen=%b), required 14", lat, seen);
        end
        checks++;
        if (cpu_hold !== 1'b0 || prev_hold !== 1'b1) begin
            failures++;
            $display("FAIL two_hold_fall got hold=%b prev=%b, required 0 1", cpu_hold, prev_hold);
        end
        checks++;
        if (wr_addr_log.size() != 2) begin
            failures++;
            $display("FAIL two_write_count got %0d, required 2", wr_addr_log.size());
        end else begin
            checks++;
            if (wr_addr_log[0] !== 5'd0 || wr_data_log[0] !== 32'h1234_5678) begin
                failures++;
                $display("FAIL two_word0 got [%0d]=%08h, required [0]=12345678",
                         wr_addr_log[0], wr_data_log[0]);
            end
            checks++;
            if (wr_addr_log[1] !== 5'd1 || wr_data_log[1] !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL two_word1 got [%0d]=%08h, required [1]=deadbeef",
                         wr_addr_log[1], wr_data_log[1]);
            end
        end
        checks++;
        if (double_we_cnt != dbl) begin
            failures++;
            $display("FAIL two_strobe_width got %0d long strobes, required 0", double_we_cnt - dbl);
        end
        @(negedge clk);
        checks++;
        if (fetch_instruction !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL two_fetch_after got %08h, required deadbeef", fetch_instruction);
        end
    endtask

    task automatic test_error;
        int n;
        n = wr_addr_log.size();
        pulse_start;
        send_byte(8'h21);
        send_byte(8'h00);
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({error, cpu_hold, byte_ready, done} !== 4'b1100) begin
            failures++;
            $display("FAIL err_state got err/hold/ready/done=%04b, required 1100",
                     {error, cpu_hold, byte_ready, done});
        end
        checks++;
        if (fetch_instruction !== 32'h0000_0000) begin
            failures++;
            $display("FAIL err_fetch_nop got %08h, required 00000000", fetch_instruction);
        end
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || wr_addr_log.size() != n) begin
            failures++;
            $display("FAIL err_sticky got error=%b writes=%0d, required 1 %0d",
                     error, wr_addr_log.size(), n);
        end
        pulse_start;
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_clear got error=%b ready=%b, required 0 1", error, byte_ready);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL err_recover got done=%b, required 1", done);
        end
    endtask

    task automatic test_full_depth;
        logic [31:0] w;
        wr_addr_log.delete();
        wr_data_log.delete();
        pulse_start;
        send_byte(8'h20);
        send_byte(8'h00);
        for (int i = 0; i < 32; i++) begin
            w = full_word(i);
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            send_byte(w[31:24]);
        end
        byte_valid = 1'b0;
        wait_done("full");
        checks++;
        if (wr_addr_log.size() != 32) begin
            failures++;
            $display("FAIL full_write_count got %0d, required 32", wr_addr_log.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (wr_addr_log[i] !== 5'(i) || wr_data_log[i] !== full_word(i)) begin
                    failures++;
                    $display("FAIL full_word%0d got [%0d]=%08h, required [%0d]=%08h",
                             i, wr_addr_log[i], wr_data_log[i], i, full_word(i));
                end
            end
        end
    endtask

    task automatic test_gaps;
        logic [7:0] bytes [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        int rdy;
        wr_addr_log.delete();
        wr_data_log.delete();
        rdy = ready_in_write_cnt;
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b0;
            if (k == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            send_byte(bytes[k]);
        end
        byte_valid = 1'b0;
        wait_done("gaps");
        checks++;
        if (wr_addr_log.size() != 1) begin
            failures++;
            $display("FAIL gaps_write_count got %0d, required 1", wr_addr_log.size());
        end else begin
            checks++;
            if (wr_addr_log[0] !== 5'd0 || wr_data_log[0] !== 32'hCAFE_F00D) begin
                failures++;
                $display("FAIL gaps_word got [%0d]=%08h, required [0]=cafef00d",
                         wr_addr_log[0], wr_data_log[0]);
            end
        end
        checks++;
        if (ready_in_write_cnt != rdy) begin
            failures++;
            $display("FAIL gaps_ready_in_write got %0d cycles, required 0", ready_in_write_cnt - rdy);
        end
    endtask

    task automatic test_fetch;
        @(negedge clk);
        fetch_address = 32'h0000_0004;
        #1;
        checks++;
        if (mem_address !== 5'd1 || fetch_instruction !== 32'h01FE_41C3) begin
            failures++;
            $display("FAIL fetch_idx1 got addr=%0d instr=%08h, required 1 01fe41c3",
                     mem_address, fetch_instruction);
        end
        fetch_address = 32'h0000_007C;
        #1;
        checks++;
        if (mem_address !== 5'd31 || fetch_instruction !== 32'h1FE0_5FC3) begin
            failures++;
            $display("FAIL fetch_idx31 got addr=%0d instr=%08h, required 31 1fe05fc3",
                     mem_address, fetch_instruction);
        end
        fetch_address = 32'h0000_0000;
        #1;
        checks++;
        if (mem_address !== 5'd0 || fetch_instruction !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL fetch_idx0 got addr=%0d instr=%08h, required 0 cafef00d",
                     mem_address, fetch_instruction);
        end
    endtask

    initial begin
        test_reset;
        test_reset_in_recv;
        test_two_words;
        test_error;
        test_full_depth;
        test_gaps;
        test_fetch;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot loader and port arbiter for the instruction memory of the single-cycle MIPS core. It receives a byte stream (16-bit word count followed by little-endian 32-bit instruction words), writes the words into a writable program memory starting at word index 0, and holds the CPU while loading. When idle or finished, it passes the CPU fetch address straight through to the same memory port.

## Interface

- MEMORY_DEPTH, 32: program memory depth in words.
- DATA_WIDTH, 32: instruction width; fixed at 32.
- ADDR_WIDTH, 5: word-index width, equal to log2(MEMORY_DEPTH).

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; single clock domain.
- start  in  1  one-cycle pulse that begins a load session.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- fetch_address  in  DATA_WIDTH  CPU program-counter byte address.
- fetch_instruction  out  DATA_WIDTH  instruction returned to the CPU.
- mem_address  out  ADDR_WIDTH  word index to program memory.
- mem_write_data  out  DATA_WIDTH  assembled word.
- mem_write_enable  out  1  program memory write strobe.
- mem_read_data  in  DATA_WIDTH  combinational read data from program memory.
- cpu_hold  out  1  stalls the PC and register writes while high.
- done  out  1  last load completed successfully (level).
- error  out  1  last load rejected (level).

## Operation

- States: IDLE, LEN_LO, LEN_HI, CHECK, RECV, WRITE, DONE, ERROR.
- A byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready=1 only in LEN_LO, LEN_HI and RECV.
- IDLE, DONE and ERROR: start=1 clears done/error, zeroes word_index and byte_index, and moves to LEN_LO. start is ignored in all other states.
- LEN_LO: the transferred byte becomes word_count[7:0], then go to LEN_HI.
- LEN_HI: the transferred byte becomes word_count[15:8], then go to CHECK.
- CHECK, one cycle:
  - word_count==0 goes to DONE.
  - word_count>MEMORY_DEPTH goes to ERROR.
  - Otherwise go to RECV.
- RECV: byte k (byte_index 0..3) goes into shift_word[8k+7:8k], so the first byte is the LSB. On the 4th transfer, go to WRITE.
- WRITE, one cycle:
  - Drive mem_write_enable=1, mem_address=word_index, mem_write_data=shift_word.
  - Then increment word_index and clear byte_index.
  - If the new word_index equals word_count, go to DONE; otherwise go to RECV.
- DONE: done=1. ERROR: error=1.
- cpu_hold=1 in LEN_LO, LEN_HI, CHECK, RECV, WRITE and ERROR; cpu_hold=0 in IDLE and DONE.
- Port mux, combinational:
  - cpu_hold=0: mem_address=fetch_address[ADDR_WIDTH+1:2] and fetch_instruction=mem_read_data.
  - cpu_hold=1: mem_address=word_index and fetch_instruction=32'h0000_0000 (NOP).
- mem_write_enable is never high outside WRITE.
- word_count is 16 bits. word_index is ADDR_WIDTH+1 bits, so a full-depth load reaches MEMORY_DEPTH without wrapping.

## Timing

- Reset (reset=0, asynchronous): state=IDLE, word_count=0, word_index=0, byte_index=0, shift_word=0, done=0, error=0.
  - Resulting outputs: cpu_hold=0, byte_ready=0, mem_write_enable=0.
- Reset asserted mid-session aborts immediately. Words already written stay in memory.
- start sampled in IDLE gives byte_ready=1 from the next cycle.
- Per word: 4 accepted bytes, then 1 WRITE cycle with byte_ready=0. Minimum 5 cycles/word with byte_valid held high.
- Gaps in byte_valid stall the FSM indefinitely with no timeout.
- Load latency, with byte_valid continuously high:
  - start to done for N words = 2 (length) + 1 (CHECK) + 5N cycles, plus the start cycle.
  - done rises on the edge after the final WRITE.
- cpu_hold falls in the same cycle done rises. The CPU's first fetch after release sees the new memory contents.
- byte_valid during WRITE, CHECK, IDLE, DONE or ERROR is not consumed (byte_ready=0).

## Test plan

- Reset while in RECV: all outputs return to their reset values; a following start with length 0 gives CHECK then done=1 with no mem_write_enable pulse.
- Load 2 words with a continuous stream 02 00 78 56 34 12 EF BE AD DE: writes 0x12345678 to index 0 and 0xDEADBEEF to index 1, each a one-cycle strobe. done=1 exactly 14 cycles after start, and cpu_hold falls in that same cycle.
- Length 33 (21 00) with MEMORY_DEPTH=32: ERROR with error=1 and cpu_hold=1, no writes. A new start clears error.
- Length 32 with a full stream: indices 0..31 written in order, no wrap, done=1.
- byte_valid toggling every other cycle during a 1-word load: the word assembles correctly with byte_ready=0 in WRITE. A start pulse mid-load is ignored.
- After done, fetch_address=0x0000_0004 returns mem_read_data of index 1. During a load, fetch_instruction=0x0000_0000.
